// File: rtl/m_mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset core: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module m_mc_ctrl #(
  parameter int P_CNT_W = 32
) (
  input  logic               w_clk,
  input  logic               w_rst,
  input  logic [5:0]         w_op,
  input  logic [5:0]         w_funct,
  input  logic               w_zero,
  input  logic               w_imem_ack,
  input  logic               w_dmem_ack,
  output logic               w_imem_req,
  output logic               w_dmem_req,
  output logic               w_dmem_we,
  output logic               w_ir_we,
  output logic               w_pc_we,
  output logic [1:0]         w_pc_sel,
  output logic               w_rf_we,
  output logic               w_rf_dst,
  output logic               w_wb_sel,
  output logic               w_alu_src,
  output logic [1:0]         w_alu_op,
  output logic [2:0]         w_state,
  output logic               w_illegal,
  output logic [P_CNT_W-1:0] w_retired
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  function automatic logic f_is_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R: begin
        case (funct)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t             state_r;
  logic               illegal_r;
  logic [P_CNT_W-1:0] retired_r;
  logic               retire_s;

  logic legal_s, is_r_s, is_j_s, is_beq_s, is_bne_s, is_br_s, is_lw_s, is_sw_s, is_mem_s;

  assign legal_s  = f_is_legal(w_op, w_funct);
  assign is_r_s   = (w_op == OP_R);
  assign is_j_s   = (w_op == OP_J);
  assign is_beq_s = (w_op == OP_BEQ);
  assign is_bne_s = (w_op == OP_BNE);
  assign is_br_s  = is_beq_s | is_bne_s;
  assign is_lw_s  = (w_op == OP_LW);
  assign is_sw_s  = (w_op == OP_SW);
  assign is_mem_s = is_lw_s | is_sw_s;

  assign w_state   = state_r;
  assign w_illegal = illegal_r;
  assign w_retired = retired_r;

  // Datapath strobes and retire pulse, decoded from the current state and inputs.
  always_comb begin
    w_imem_req = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 2'b00;
    w_rf_we    = 1'b0;
    w_rf_dst   = 1'b0;
    w_wb_sel   = 1'b0;
    w_alu_src  = 1'b0;
    w_alu_op   = 2'b00;
    retire_s   = 1'b0;
    if (w_rst) begin
      retire_s = 1'b0;
    end else begin
      case (state_r)
        ST_IF: begin
          w_imem_req = 1'b1;
          w_ir_we    = w_imem_ack;
          w_pc_we    = w_imem_ack;
        end
        ST_ID: begin
          w_pc_we  = legal_s & is_j_s;
          w_pc_sel = is_j_s ? 2'b10 : 2'b00;
          retire_s = legal_s & is_j_s;
        end
        ST_EX: begin
          w_alu_src = ~(is_r_s | is_br_s);
          w_alu_op  = is_r_s ? 2'b10 : (is_br_s ? 2'b01 : 2'b00);
          w_pc_we   = (is_beq_s & w_zero) | (is_bne_s & ~w_zero);
          w_pc_sel  = is_br_s ? 2'b01 : 2'b00;
          retire_s  = is_br_s;
        end
        ST_MEM: begin
          w_dmem_req = 1'b1;
          w_dmem_we  = is_sw_s;
          w_alu_src  = 1'b1;
          retire_s   = w_dmem_ack & is_sw_s;
        end
        ST_WB: begin
          w_rf_we  = 1'b1;
          w_rf_dst = is_r_s;
          w_wb_sel = is_lw_s;
          retire_s = 1'b1;
        end
        ST_HALT: retire_s = 1'b0;
        default: retire_s = 1'b0;
      endcase
    end
  end

  // State sequencing, sticky illegal flag and retired-instruction counter.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_r   <= ST_IF;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      if (retire_s) begin
        retired_r <= retired_r + P_CNT_W'(1);
      end
      case (state_r)
        ST_IF: begin
          if (w_imem_ack) state_r <= ST_ID;
        end
        ST_ID: begin
          if (!legal_s) begin
            state_r   <= ST_HALT;
            illegal_r <= 1'b1;
          end else if (is_j_s) begin
            state_r <= ST_IF;
          end else begin
            state_r <= ST_EX;
          end
        end
        ST_EX: begin
          if (is_br_s)       state_r <= ST_IF;
          else if (is_mem_s) state_r <= ST_MEM;
          else               state_r <= ST_WB;
        end
        ST_MEM: begin
          if (w_dmem_ack) state_r <= is_sw_s ? ST_IF : ST_WB;
        end
        ST_WB:   state_r <= ST_IF;
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Self-checking bench for m_mc_ctrl: each instruction is expanded into its
// expected per-cycle trace from the sequencing rules, then driven and compared.
module tb_m_mc_ctrl;

  logic       clk = 1'b0;
  logic       w_rst, w_zero, w_imem_ack, w_dmem_ack;
  logic [5:0] w_op, w_funct;
  logic       w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we;
  logic [1:0] w_pc_sel, w_alu_op;
  logic       w_rf_we, w_rf_dst, w_wb_sel, w_alu_src, w_illegal;
  logic [2:0] w_state;
  logic [3:0] w_retired;

  m_mc_ctrl #(.P_CNT_W(4)) dut (
    .w_clk(clk), .w_rst(w_rst), .w_op(w_op), .w_funct(w_funct), .w_zero(w_zero),
    .w_imem_ack(w_imem_ack), .w_dmem_ack(w_dmem_ack),
    .w_imem_req(w_imem_req), .w_dmem_req(w_dmem_req), .w_dmem_we(w_dmem_we),
    .w_ir_we(w_ir_we), .w_pc_we(w_pc_we), .w_pc_sel(w_pc_sel), .w_rf_we(w_rf_we),
    .w_rf_dst(w_rf_dst), .w_wb_sel(w_wb_sel), .w_alu_src(w_alu_src),
    .w_alu_op(w_alu_op), .w_state(w_state), .w_illegal(w_illegal),
    .w_retired(w_retired)
  );

  always #5 clk = ~clk;

  // {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel[1:0], rf_we, rf_dst, wb_sel, alu_src, alu_op[1:0]}
  logic [12:0] obs_strb;
  assign obs_strb = {w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_pc_sel,
                     w_rf_we, w_rf_dst, w_wb_sel, w_alu_src, w_alu_op};

  typedef struct packed {
    logic        ia;
    logic        da;
    logic [2:0]  st;
    logic [12:0] strb;
    logic        ret;
    logic        ill;
  } cyc_t;

  cyc_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_ret;
  logic       exp_ill;

  function automatic logic [12:0] sv(input logic imr, input logic dmr, input logic dwe,
                                     input logic irwe, input logic pcwe, input logic [1:0] psel,
                                     input logic rfwe, input logic rfd, input logic wbs,
                                     input logic asrc, input logic [1:0] aop);
    return {imr, dmr, dwe, irwe, pcwe, psel, rfwe, rfd, wbs, asrc, aop};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] f);
    if (op == 6'h00) return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    return op inside {6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic ia, input logic da, input logic [2:0] st,
                      input logic [12:0] s, input logic ret, input logic ill);
    cyc_t c;
    c.ia = ia; c.da = da; c.st = st; c.strb = s; c.ret = ret; c.ill = ill;
    q.push_back(c);
  endtask

  // Expected trace of one instruction: idly IF wait cycles, ddly MEM wait cycles.
  task automatic build(input logic [5:0] op, input logic [5:0] f, input logic z,
                       input int idly, input int ddly);
    logic r, lw, sw, br, taken;
    w_op = op; w_funct = f; w_zero = z;
    r  = (op == 6'h00); lw = (op == 6'h23); sw = (op == 6'h2b);
    br = (op == 6'h04) || (op == 6'h05);
    taken = ((op == 6'h04) && z) || ((op == 6'h05) && !z);
    for (int i = 0; i < idly; i++)
      push(1'b0, rb(), 3'd0, sv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 1'b0);
    push(1'b1, rb(), 3'd0, sv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 1'b0);
    if (!is_legal(op, f)) begin
      push(rb(), rb(), 3'd1, 13'd0, 1'b0, 1'b1);
      return;
    end
    if (op == 6'h02) begin
      push(rb(), rb(), 3'd1, sv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b1, 1'b0);
      return;
    end
    push(rb(), rb(), 3'd1, 13'd0, 1'b0, 1'b0);
    if (br) begin
      push(rb(), rb(), 3'd2, sv(1'b0, 1'b0, 1'b0, 1'b0, taken, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01), 1'b1, 1'b0);
      return;
    end
    push(rb(), rb(), 3'd2, sv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, !r, r ? 2'b10 : 2'b00), 1'b0, 1'b0);
    if (lw || sw) begin
      for (int i = 0; i < ddly; i++)
        push(rb(), 1'b0, 3'd3, sv(1'b0, 1'b1, sw, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00), 1'b0, 1'b0);
      push(rb(), 1'b1, 3'd3, sv(1'b0, 1'b1, sw, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00), sw, 1'b0);
      if (sw) return;
    end
    push(rb(), rb(), 3'd4, sv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, r, lw, 1'b0, 2'b00), 1'b1, 1'b0);
  endtask

  task automatic exec_n(input int n, input string tag);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      w_imem_ack = c.ia; w_dmem_ack = c.da;
      @(negedge clk);
      chk(tag, {11'd0, w_state, obs_strb, w_illegal, w_retired},
               {11'd0, c.st, c.strb, exp_ill, exp_ret});
      @(posedge clk); #1;
      if (c.ret) exp_ret++;
      if (c.ill) exp_ill = 1'b1;
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] f,
                          input logic z, input int idly, input int ddly);
    build(op, f, z, idly, ddly);
    exec_n(1000, tag);
  endtask

  task automatic do_halt(input int n);
    for (int i = 0; i < n; i++) push(1'b1 ^ i[0], rb(), 3'd5, 13'd0, 1'b0, 1'b0);
    exec_n(n, "halt");
  endtask

  task automatic do_reset(input int n);
    w_rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      w_imem_ack = 1'b1; w_dmem_ack = 1'b1;
      @(negedge clk);
      chk("rst_strobes", {19'd0, obs_strb}, 32'd0);
      @(posedge clk); #1;
    end
    w_rst = 1'b0;
    exp_ret = 4'd0; exp_ill = 1'b0;
    chk("rst_state", {24'd0, w_state, w_illegal, w_retired}, 32'd0);
  endtask

  logic [11:0] tab [10] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h2a},
    {6'h02, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00}
  };

  initial begin
    logic [11:0] e;
    w_rst = 1'b1; w_op = 6'h00; w_funct = 6'h00; w_zero = 1'b0;
    w_imem_ack = 1'b0; w_dmem_ack = 1'b0;
    exp_ret = 4'd0; exp_ill = 1'b0;
    #1;
    do_reset(2);

    do_instr("addi", 6'h08, 6'h11, 1'b0, 0, 0);
    chk("addi_retired", {28'd0, w_retired}, 32'd1);
    do_instr("bne_nz", 6'h05, 6'h3e, 1'b0, 0, 0);
    do_instr("bne_z", 6'h05, 6'h3e, 1'b1, 0, 0);
    do_instr("beq_z", 6'h04, 6'h01, 1'b1, 1, 0);
    do_instr("beq_nz", 6'h04, 6'h01, 1'b0, 0, 0);
    do_instr("lw_late", 6'h23, 6'h00, 1'b0, 0, 3);
    do_instr("sw", 6'h2b, 6'h07, 1'b1, 2, 1);
    do_instr("r_slt", 6'h00, 6'h2a, 1'b0, 0, 0);
    do_instr("j", 6'h02, 6'h15, 1'b0, 3, 0);

    for (int k = 0; k < 40; k++) begin
      e = tab[$urandom_range(9, 0)];
      do_instr("rand", e[11:6], (e[11:6] == 6'h00) ? e[5:0] : 6'($urandom),
               rb(), $urandom_range(3, 0), $urandom_range(3, 0));
    end

    // reset while a store is waiting on the data memory
    build(6'h2b, 6'h00, 1'b0, 0, 5);
    exec_n(4, "sw_pre_rst");
    q.delete();
    do_reset(1);
    do_instr("post_rst", 6'h08, 6'h00, 1'b0, 0, 0);

    do_reset(1);
    for (int k = 0; k < 15; k++) do_instr("wrap_j", 6'h02, 6'h00, 1'b0, 0, 0);
    chk("wrap_15", {28'd0, w_retired}, 32'd15);
    do_instr("wrap_j", 6'h02, 6'h00, 1'b0, 0, 0);
    chk("wrap_0", {28'd0, w_retired}, 32'd0);

    do_instr("pre_ill", 6'h00, 6'h20, 1'b0, 0, 0);
    do_instr("ill_op", 6'h3f, 6'h00, 1'b0, 1, 0);
    do_halt(6);
    do_reset(2);
    do_instr("ill_funct", 6'h00, 6'h21, 1'b0, 0, 0);
    do_halt(3);
    do_reset(1);
    do_instr("final", 6'h23, 6'h00, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
